data_memory_unit: RTL and testbench
===================================

// Module: data_memory_unit
// PURPOSE
//  Data-side memory stage consumed by the pipelined RV32I core. Takes the core's M-stage
//  outputs (MemWriteM, ALUResultM, WriteDataM, Func3M) and returns ReadDataM in the same
//  cycle. ReadDataM is already sign- or zero-extended. Stores commit with byte lanes set by
//  Func3M, on the rising clock edge. Also keeps a sticky misaligned/illegal-store error with
//  the captured address, and a committed-store counter for bring-up and debug.
// PARAMETERS
//  ADDR_BITS  8   word-index width; array holds 2**ADDR_BITS 32-bit words
//  CNT_W      32  width of StoreCount
// PORTS
//  clk         in   1         rising-edge clock
//  reset       in   1         asynchronous, active-low reset
//  MemWriteM   in   1         store request for the current M-stage instruction
//  ALUResultM  in   32        byte address
//  WriteDataM  in   32        store data; low bits hold the byte/half payload
//  Func3M      in   3         RV32I funct3 of the load/store
//  ErrClr      in   1         synchronous clear of StoreErr/ErrAddr
//  ReadDataM   out  32        extended load data (combinational)
//  StoreErr    out  1         sticky: a store was dropped as misaligned or illegal
//  ErrAddr     out  32        address of the first dropped store since the last clear
//  StoreCount  out  CNT_W     number of committed stores
// BEHAVIOUR
//  Reset (reset=0, async): StoreErr=0, ErrAddr=0, StoreCount=0. The RAM array is NOT reset.
//  Index = ALUResultM[ADDR_BITS+1:2]. Upper address bits are ignored, so addresses alias modulo array size.
//  Lane = ALUResultM[1:0]. Little-endian: byte k sits at bits [8k+7:8k].
//  Store, at posedge when MemWriteM=1:
//   - 000 SB: write lane A[1:0] with WriteDataM[7:0].
//   - 001 SH: A[0]=0 required; write lanes {A[1],0},{A[1],1} with WriteDataM[15:0].
//   - 010 SW: A[1:0]=00 required; write all 4 lanes.
//   - Any other funct3, or an alignment violation: no array write and no count. Set StoreErr.
//     Load ErrAddr=ALUResultM only if StoreErr was 0 before this edge (first error wins).
//   - A legal store increments StoreCount, wrapping at 2**CNT_W.
//  Load path (combinational, independent of MemWriteM): word W = mem[Index].
//   - 000 LB:  sign-extend byte A[1:0].
//   - 100 LBU: zero-extend byte A[1:0].
//   - 001 LH:  sign-extend half A[1]; A[0] is ignored.
//   - 101 LHU: zero-extend half A[1]; A[0] is ignored.
//   - 010 LW:  return W; A[1:0] are ignored.
//   - Other funct3: return 0.
//  Same-cycle read and write to one word: ReadDataM shows the pre-edge contents. New data is visible from the next cycle.
//  ErrClr=1 at posedge: StoreErr<=0, ErrAddr<=0.
//  ErrClr=1 together with a new bad store: the set wins. StoreErr=1 and ErrAddr=the new address.
//  Reset asserted mid-store: the array write for that edge is not guaranteed. Registers go to reset values immediately.
//  Latency: store = 1 edge. Load = 0 cycles (combinational). Both error and counter update on the same edge as the store.
// TESTING
//  1. SW 0x80000001 @0x10; LW @0x10 -> 0x80000001; LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; StoreCount=1.
//  2. SB 0xAB @0x21 over word 0x11223344 -> LW @0x20=0x1122AB44. SH 0xBEEF @0x22 -> LW=0xBEEFAB44; LH @0x22=0xFFFFBEEF.
//  3. SW @0x06 then SH @0x09 -> no array change; StoreErr=1; ErrAddr=0x06 (second error ignored); StoreCount unchanged.
//  4. ErrClr together with a bad SW @0x0A -> StoreErr stays 1, ErrAddr=0x0A. ErrClr alone next cycle -> StoreErr=0, ErrAddr=0.
//  5. CNT_W=4: 17 legal stores -> StoreCount=1 (wrap). Address 0x400 with ADDR_BITS=8 aliases 0x000 (LW returns the same word).
//  6. Pull reset low between edges -> StoreErr/ErrAddr/StoreCount clear at once; previously written RAM word still reads back.

Source files
------------

// File: rtl/data_memory_unit.sv
// Data-side memory stage: combinational extended loads, byte-lane stores on the rising edge,
// sticky store-error capture and a committed-store counter.
module data_memory_unit #(
  parameter int ADDR_BITS = 8,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWriteM,
  input  logic [31:0]      ALUResultM,
  input  logic [31:0]      WriteDataM,
  input  logic [2:0]       Func3M,
  input  logic             ErrClr,
  output logic [31:0]      ReadDataM,
  output logic             StoreErr,
  output logic [31:0]      ErrAddr,
  output logic [CNT_W-1:0] StoreCount
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [31:0]          mem_q [DEPTH];
  logic [ADDR_BITS-1:0] idx;
  logic [1:0]           lane;
  logic [31:0]          word;
  logic [7:0]           byte_v;
  logic [15:0]          half_v;

  logic [3:0]  be;
  logic [31:0] wlanes;
  logic        legal;
  logic        wr_en;
  logic        bad_st;

  logic             err_q, err_d;
  logic [31:0]      eaddr_q, eaddr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign idx  = ALUResultM[ADDR_BITS+1:2];
  assign lane = ALUResultM[1:0];

  // Store lane decode; upper address bits only matter for ErrAddr
  always_comb begin
    be     = 4'b0000;
    wlanes = 32'h0;
    legal  = 1'b0;
    case (Func3M)
      3'b000: begin
        be     = 4'b0001 << lane;
        wlanes = {4{WriteDataM[7:0]}};
        legal  = 1'b1;
      end
      3'b001: begin
        be     = lane[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{WriteDataM[15:0]}};
        legal  = ~lane[0];
      end
      3'b010: begin
        be     = 4'b1111;
        wlanes = WriteDataM;
        legal  = (lane == 2'b00);
      end
      default: begin
        be     = 4'b0000;
        wlanes = 32'h0;
        legal  = 1'b0;
      end
    endcase
  end

  assign wr_en  = MemWriteM & legal;
  assign bad_st = MemWriteM & ~legal;

  // Array is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem_q[idx][8*k +: 8] <= wlanes[8*k +: 8];
      end
    end
  end

  assign word   = mem_q[idx];
  assign byte_v = word[{lane, 3'b000} +: 8];
  assign half_v = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    case (Func3M)
      3'b000:  ReadDataM = {{24{byte_v[7]}}, byte_v};
      3'b100:  ReadDataM = {24'h0, byte_v};
      3'b001:  ReadDataM = {{16{half_v[15]}}, half_v};
      3'b101:  ReadDataM = {16'h0, half_v};
      3'b010:  ReadDataM = word;
      default: ReadDataM = 32'h0;
    endcase
  end

  // A new bad store beats a same-edge clear; otherwise the first error's address is held
  always_comb begin
    err_d   = err_q;
    eaddr_d = eaddr_q;
    if (ErrClr) begin
      err_d   = 1'b0;
      eaddr_d = 32'h0;
    end
    if (bad_st) begin
      err_d = 1'b1;
      if (!err_q || ErrClr) eaddr_d = ALUResultM;
    end
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, wr_en};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q   <= 1'b0;
      eaddr_q <= 32'h0;
      cnt_q   <= '0;
    end else begin
      err_q   <= err_d;
      eaddr_q <= eaddr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign StoreErr   = err_q;
  assign ErrAddr    = eaddr_q;
  assign StoreCount = cnt_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: directed vector table, hand-written corner sequences and
// randomized traffic checked against a byte-array reference model.
module tb_data_memory_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [2:0]  Func3M;
  logic        ErrClr;
  logic [31:0] ReadDataM;
  logic        StoreErr;
  logic [31:0] ErrAddr;
  logic [31:0] StoreCount;

  logic [31:0] rd4;
  logic        err4;
  logic [31:0] ea4;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  data_memory_unit u_dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .Func3M(Func3M), .ErrClr(ErrClr),
    .ReadDataM(ReadDataM), .StoreErr(StoreErr), .ErrAddr(ErrAddr), .StoreCount(StoreCount)
  );

  data_memory_unit #(.ADDR_BITS(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .Func3M(Func3M), .ErrClr(ErrClr),
    .ReadDataM(rd4), .StoreErr(err4), .ErrAddr(ea4), .StoreCount(cnt4)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: 1 KiB byte array, error flag/address, unbounded counter
  logic [7:0]  m_mem [1024];
  logic        m_err;
  logic [31:0] m_ea;
  int unsigned m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [2:0] f3);
    int b = int'(a % 1024);
    int w = b - (b % 4);
    int h = w + (((b % 4) >= 2) ? 2 : 0);
    logic [15:0] hv = {m_mem[h+1], m_mem[h]};
    case (f3)
      3'd0: return {{24{m_mem[b][7]}}, m_mem[b]};
      3'd4: return {24'h0, m_mem[b]};
      3'd1: return {{16{hv[15]}}, hv};
      3'd5: return {16'h0, hv};
      3'd2: return {m_mem[w+3], m_mem[w+2], m_mem[w+1], m_mem[w]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit mdl_legal(input logic [31:0] a, input logic [2:0] f3);
    return (f3 == 3'd0) || (f3 == 3'd1 && a % 2 == 0) || (f3 == 3'd2 && a % 4 == 0);
  endfunction

  task automatic mdl_edge(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic clr);
    bit was_err = m_err;
    int nbytes = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    if (clr) begin
      m_err = 1'b0;
      m_ea  = 32'h0;
    end
    if (we) begin
      if (mdl_legal(a, f3)) begin
        for (int i = 0; i < nbytes; i++) m_mem[int'(a % 1024) + i] = wd[8*i +: 8];
        m_cnt++;
      end else begin
        if (clr || !was_err) m_ea = a;
        m_err = 1'b1;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the following edge
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic clr, input bit chk_rd,
                       output logic [31:0] rd_pre);
    MemWriteM  = we;
    Func3M     = f3;
    ALUResultM = a;
    WriteDataM = wd;
    ErrClr     = clr;
    #2;
    rd_pre = ReadDataM;
    if (chk_rd) chk("rd_model", ReadDataM, mdl_load(a, f3));
    @(posedge clk);
    mdl_edge(we, f3, a, wd, clr);
    #1;
    chk("err_model", {31'h0, StoreErr}, {31'h0, m_err});
    chk("eaddr_model", ErrAddr, m_ea);
    chk("cnt_model", StoreCount, m_cnt);
    chk("cnt4_model", {28'h0, cnt4}, m_cnt % 16);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        clr;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] exp_ea;
  } vec_t;

  vec_t tbl [19];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] w0;
    int unsigned c0;

    tbl[0]  = '{1'b1, 3'd2, 32'h10, 32'h8000_0001, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0};
    tbl[1]  = '{1'b0, 3'd2, 32'h10, 32'h0,         1'b0, 1'b1, 32'h8000_0001,  1'b0, 32'h0};
    tbl[2]  = '{1'b0, 3'd0, 32'h13, 32'h0,         1'b0, 1'b1, 32'hFFFF_FF80,  1'b0, 32'h0};
    tbl[3]  = '{1'b0, 3'd4, 32'h13, 32'h0,         1'b0, 1'b1, 32'h0000_0080,  1'b0, 32'h0};
    tbl[4]  = '{1'b1, 3'd2, 32'h20, 32'h1122_3344, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0};
    tbl[5]  = '{1'b1, 3'd0, 32'h21, 32'hFFFF_FFAB, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0};
    tbl[6]  = '{1'b0, 3'd2, 32'h20, 32'h0,         1'b0, 1'b1, 32'h1122_AB44,  1'b0, 32'h0};
    tbl[7]  = '{1'b1, 3'd1, 32'h22, 32'h1234_BEEF, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0};
    tbl[8]  = '{1'b0, 3'd2, 32'h20, 32'h0,         1'b0, 1'b1, 32'hBEEF_AB44,  1'b0, 32'h0};
    tbl[9]  = '{1'b0, 3'd1, 32'h22, 32'h0,         1'b0, 1'b1, 32'hFFFF_BEEF,  1'b0, 32'h0};
    tbl[10] = '{1'b0, 3'd5, 32'h23, 32'h0,         1'b0, 1'b1, 32'h0000_BEEF,  1'b0, 32'h0};
    tbl[11] = '{1'b0, 3'd1, 32'h20, 32'h0,         1'b0, 1'b1, 32'hFFFF_AB44,  1'b0, 32'h0};
    tbl[12] = '{1'b0, 3'd3, 32'h20, 32'h0,         1'b0, 1'b1, 32'h0,          1'b0, 32'h0};
    tbl[13] = '{1'b1, 3'd2, 32'h06, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,          1'b1, 32'h06};
    tbl[14] = '{1'b1, 3'd1, 32'h09, 32'h0000_5555, 1'b0, 1'b0, 32'h0,          1'b1, 32'h06};
    tbl[15] = '{1'b1, 3'd2, 32'h0A, 32'h1111_1111, 1'b1, 1'b0, 32'h0,          1'b1, 32'h0A};
    tbl[16] = '{1'b0, 3'd2, 32'h0A, 32'h0,         1'b1, 1'b0, 32'h0,          1'b0, 32'h0};
    tbl[17] = '{1'b1, 3'd3, 32'h30, 32'h0,         1'b0, 1'b0, 32'h0,          1'b1, 32'h30};
    tbl[18] = '{1'b0, 3'd0, 32'h30, 32'h0,         1'b1, 1'b0, 32'h0,          1'b0, 32'h0};

    reset = 1'b0; MemWriteM = 1'b0; ALUResultM = 32'h0; WriteDataM = 32'h0;
    Func3M = 3'd0; ErrClr = 1'b0;
    m_err = 1'b0; m_ea = 32'h0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_err", {31'h0, StoreErr}, 32'h0);
    chk("rst_eaddr", ErrAddr, 32'h0);
    chk("rst_cnt", StoreCount, 32'h0);
    reset = 1'b1;

    // Fill every word so the model is fully known
    for (int i = 0; i < 256; i++) do_op(1'b1, 3'd2, 32'(i * 4), $urandom, 1'b0, 1'b0, rd);

    for (int i = 0; i < 19; i++) begin
      do_op(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].clr, 1'b1, rd);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), {31'h0, StoreErr}, {31'h0, tbl[i].exp_err});
      chk($sformatf("tbl%0d_eaddr", i), ErrAddr, tbl[i].exp_ea);
    end

    // Dropped stores leave the array and counter untouched
    c0 = m_cnt;
    do_op(1'b1, 3'd2, 32'h46, 32'hFFFF_FFFF, 1'b0, 1'b1, rd);
    do_op(1'b1, 3'd1, 32'h45, 32'hFFFF_FFFF, 1'b0, 1'b1, rd);
    do_op(1'b0, 3'd2, 32'h44, 32'h0, 1'b0, 1'b1, rd);
    chk("bad_no_count", StoreCount, c0);
    do_op(1'b0, 3'd2, 32'h0, 32'h0, 1'b1, 1'b1, rd);

    // Aliasing: 0x400 maps onto word 0; store via alias, read via base
    w0 = mdl_load(32'h0, 3'd2);
    do_op(1'b0, 3'd2, 32'h400, 32'h0, 1'b0, 1'b0, rd);
    chk("alias_rd", rd, w0);
    do_op(1'b1, 3'd2, 32'hABC0_0410, 32'hCAFE_F00D, 1'b0, 1'b1, rd);
    do_op(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 1'b1, rd);
    chk("alias_wr", rd, 32'hCAFE_F00D);

    // 4-bit counter wraps after 16 stores
    c0 = m_cnt;
    for (int i = 0; i < 17; i++) do_op(1'b1, 3'd0, 32'(64 + i), 32'(i), 1'b0, 1'b1, rd);
    chk("cnt4_wrap", {28'h0, cnt4}, (c0 + 1) % 16);

    // Async reset between edges clears registers immediately, RAM keeps data
    do_op(1'b1, 3'd2, 32'h2, 32'h0, 1'b0, 1'b1, rd);
    MemWriteM = 1'b0; Func3M = 3'd2; ALUResultM = 32'h10; ErrClr = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_err", {31'h0, StoreErr}, 32'h0);
    chk("async_eaddr", ErrAddr, 32'h0);
    chk("async_cnt", StoreCount, 32'h0);
    chk("async_cnt4", {28'h0, cnt4}, 32'h0);
    chk("async_ram", ReadDataM, 32'hCAFE_F00D);
    #1 reset = 1'b1;
    m_err = 1'b0; m_ea = 32'h0; m_cnt = 0;
    @(posedge clk);
    #1;

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      logic [31:0] a;
      logic [2:0]  f3;
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & 32'h3FF;
      f3 = ($urandom_range(0, 4) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      do_op(1'($urandom_range(0, 1)), f3, a, $urandom, ($urandom_range(0, 7) == 0), 1'b1, rd);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
